// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared types and constants for the exception sequencing controller
// Contents: controller state enum, request kind enum, cause codes,
// CP0 register indices and CP0 Status/Cause bit positions.
package exc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_EPC,
        S_W_CAUSE,
        S_W_STATUS,
        S_REDIR,
        S_ERET_ST,
        S_ERET_RED,
        S_SKIP
    } state_t;

    // What the winning request turns into once its enable has been applied
    typedef enum logic [1:0] {
        K_ERET,
        K_EXC,
        K_INT,
        K_SKIP
    } kind_t;

    localparam logic [4:0] CODE_INT = 5'd0;
    localparam logic [4:0] CODE_SYS = 5'd8;
    localparam logic [4:0] CODE_BRK = 5'd9;
    localparam logic [4:0] CODE_TEQ = 5'd13;

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;

    localparam int ST_IE       = 0;
    localparam int ST_SYS_EN   = 1;
    localparam int ST_BRK_EN   = 2;
    localparam int ST_TEQ_EN   = 3;
    localparam int ST_IRQ_MASK = 10;

    localparam int CAUSE_CODE_LSB = 2;
    localparam int CAUSE_IP_LSB   = 10;

endpackage

// File: rtl/exc_prio.sv
// rtl/exc_prio.sv - combinational request priority encoder for exc_ctrl
// Inputs : req_eret/req_syscall/req_break/req_teq request pulses,
//          en_sys/en_brk/en_teq enables, irq_elig eligible pending IRQs.
// Outputs: valid (something to accept), kind, code (cause code),
//          irq_hot (one-hot of the taken IRQ line, zero otherwise).
module exc_prio
    import exc_pkg::*;
#(
    parameter int IRQ_W = 6
) (
    input  logic             req_eret,
    input  logic             req_syscall,
    input  logic             req_break,
    input  logic             req_teq,
    input  logic             en_sys,
    input  logic             en_brk,
    input  logic             en_teq,
    input  logic [IRQ_W-1:0] irq_elig,
    output logic             valid,
    output kind_t            kind,
    output logic [4:0]       code,
    output logic [IRQ_W-1:0] irq_hot
);

    always_comb begin
        valid   = 1'b0;
        kind    = K_ERET;
        code    = CODE_INT;
        irq_hot = '0;
        if (req_eret) begin
            valid = 1'b1;
            kind  = K_ERET;
        end else if (req_syscall) begin
            valid = 1'b1;
            kind  = en_sys ? K_EXC : K_SKIP;
            code  = CODE_SYS;
        end else if (req_break) begin
            valid = 1'b1;
            kind  = en_brk ? K_EXC : K_SKIP;
            code  = CODE_BRK;
        end else if (req_teq) begin
            valid = 1'b1;
            kind  = en_teq ? K_EXC : K_SKIP;
            code  = CODE_TEQ;
        end else if (|irq_elig) begin
            valid   = 1'b1;
            kind    = K_INT;
            code    = CODE_INT;
            // isolate the lowest set bit: x & -x
            irq_hot = irq_elig & (~irq_elig + IRQ_W'(1));
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception sequencing controller between core and CP0
// Inputs : clk, rst (async active-low), req_eret/req_syscall/req_break/req_teq,
//          irq levels, ex_pc, core MTC0 port (cpu_mtc0/cpu_addr/cpu_wdata),
//          current CP0 status/cause/epc.
// Outputs: CP0 write port (cp0_we/cp0_waddr/cp0_wdata), stall,
//          redirect strobe and redirect_pc.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] VECTOR = 32'h0000_0004,
    parameter int          IRQ_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_eret,
    input  logic             req_syscall,
    input  logic             req_break,
    input  logic             req_teq,
    input  logic [IRQ_W-1:0] irq,
    input  logic [31:0]      ex_pc,
    input  logic             cpu_mtc0,
    input  logic [4:0]       cpu_addr,
    input  logic [31:0]      cpu_wdata,
    input  logic [31:0]      cp0_status,
    input  logic [31:0]      cp0_cause,
    input  logic [31:0]      cp0_epc,
    output logic             cp0_we,
    output logic [4:0]       cp0_waddr,
    output logic [31:0]      cp0_wdata,
    output logic             stall,
    output logic             redirect,
    output logic [31:0]      redirect_pc
);

    state_t           state;
    logic [IRQ_W-1:0] irq_pend;
    logic [IRQ_W-1:0] irq_q;
    logic [31:0]      pc_q;
    logic [4:0]       code_q;

    logic             p_valid;
    kind_t            p_kind;
    logic [4:0]       p_code;
    logic [IRQ_W-1:0] p_hot;
    logic [IRQ_W-1:0] irq_elig;
    logic [31:0]      cause_new;

    assign irq_elig = irq_pend & cp0_status[ST_IRQ_MASK +: IRQ_W]
                      & {IRQ_W{cp0_status[ST_IE]}};

    exc_prio #(.IRQ_W(IRQ_W)) u_prio (
        .req_eret    (req_eret),
        .req_syscall (req_syscall),
        .req_break   (req_break),
        .req_teq     (req_teq),
        .en_sys      (cp0_status[ST_SYS_EN]),
        .en_brk      (cp0_status[ST_BRK_EN]),
        .en_teq      (cp0_status[ST_TEQ_EN]),
        .irq_elig    (irq_elig),
        .valid       (p_valid),
        .kind        (p_kind),
        .code        (p_code),
        .irq_hot     (p_hot)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            irq_pend <= '0;
            irq_q    <= '0;
            pc_q     <= '0;
            code_q   <= '0;
        end else begin
            // irq_q is non-zero only for a taken interrupt; its pend bit is
            // retired in the cycle the Cause write reports it
            irq_pend <= (irq_pend | irq) & ((state == S_W_CAUSE) ? ~irq_q : '1);
            case (state)
                S_IDLE: begin
                    if (p_valid) begin
                        pc_q   <= ex_pc;
                        code_q <= p_code;
                        irq_q  <= p_hot;
                        case (p_kind)
                            K_ERET:  state <= S_ERET_ST;
                            K_SKIP:  state <= S_SKIP;
                            default: state <= S_W_EPC;
                        endcase
                    end
                end
                S_W_EPC:    state <= S_W_CAUSE;
                S_W_CAUSE:  state <= S_W_STATUS;
                S_W_STATUS: state <= S_REDIR;
                S_ERET_ST:  state <= S_ERET_RED;
                default:    state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        cause_new = cp0_cause;
        cause_new[CAUSE_CODE_LSB +: 5] = code_q;
        if (|irq_q) begin
            cause_new[CAUSE_IP_LSB +: IRQ_W] = irq_q;
        end

        cp0_we      = 1'b0;
        cp0_waddr   = '0;
        cp0_wdata   = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        case (state)
            S_IDLE: begin
                cp0_we    = cpu_mtc0;
                cp0_waddr = cpu_addr;
                cp0_wdata = cpu_wdata;
            end
            S_W_EPC: begin
                cp0_we    = 1'b1;
                cp0_waddr = REG_EPC;
                cp0_wdata = pc_q;
            end
            S_W_CAUSE: begin
                cp0_we    = 1'b1;
                cp0_waddr = REG_CAUSE;
                cp0_wdata = cause_new;
            end
            S_W_STATUS: begin
                cp0_we    = 1'b1;
                cp0_waddr = REG_STATUS;
                cp0_wdata = cp0_status << 5;
            end
            S_REDIR: begin
                redirect    = 1'b1;
                redirect_pc = VECTOR;
            end
            S_ERET_ST: begin
                cp0_we    = 1'b1;
                cp0_waddr = REG_STATUS;
                cp0_wdata = cp0_status >> 5;
            end
            S_ERET_RED: begin
                redirect    = 1'b1;
                redirect_pc = cp0_epc;
            end
            S_SKIP: begin
                redirect    = 1'b1;
                redirect_pc = pc_q + 32'd4;
            end
            default: ;
        endcase

        // nothing leaks out, not even the core passthrough, while in reset
        if (!rst) begin
            cp0_we      = 1'b0;
            cp0_waddr   = '0;
            cp0_wdata   = '0;
            redirect    = 1'b0;
            redirect_pc = '0;
        end
    end

    assign stall = rst && (state != S_IDLE);

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed self-checking bench for exc_ctrl
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_eret = 1'b0, req_syscall = 1'b0, req_break = 1'b0, req_teq = 1'b0;
    logic [5:0]  irq = '0;
    logic [31:0] ex_pc = '0;
    logic        cpu_mtc0 = 1'b0;
    logic [4:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cp0_status = '0, cp0_cause = '0, cp0_epc = '0;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        stall, redirect;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    exc_ctrl #(.VECTOR(32'h0000_0004), .IRQ_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_eret    (req_eret),
        .req_syscall (req_syscall),
        .req_break   (req_break),
        .req_teq     (req_teq),
        .irq         (irq),
        .ex_pc       (ex_pc),
        .cpu_mtc0    (cpu_mtc0),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cp0_status  (cp0_status),
        .cp0_cause   (cp0_cause),
        .cp0_epc     (cp0_epc),
        .cp0_we      (cp0_we),
        .cp0_waddr   (cp0_waddr),
        .cp0_wdata   (cp0_wdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_write(input string tag, input logic [4:0] addr, input logic [31:0] data);
        chk({tag, "_we"},   32'(cp0_we), 32'h1);
        chk({tag, "_addr"}, 32'(cp0_waddr), 32'(addr));
        chk({tag, "_data"}, cp0_wdata, data);
        chk({tag, "_stall"}, 32'(stall), 32'h1);
    endtask

    task automatic chk_redir(input string tag, input logic [31:0] pc);
        chk({tag, "_redir"}, 32'(redirect), 32'h1);
        chk({tag, "_rpc"},   redirect_pc, pc);
        chk({tag, "_we"},    32'(cp0_we), 32'h0);
        chk({tag, "_stall"}, 32'(stall), 32'h1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'h0);
        chk({tag, "_redir"}, 32'(redirect), 32'h0);
    endtask

    initial begin
        // reset: outputs forced low, no passthrough
        cpu_mtc0 = 1'b1; cpu_addr = 5'd5; cpu_wdata = 32'h0000_abcd;
        #1;
        chk("rst_we", 32'(cp0_we), 32'h0);
        chk("rst_waddr", 32'(cp0_waddr), 32'h0);
        chk("rst_wdata", cp0_wdata, 32'h0);
        chk_idle("rst");
        step(); step();
        rst = 1'b1;
        #1;
        chk("pass_we", 32'(cp0_we), 32'h1);
        chk("pass_addr", 32'(cp0_waddr), 32'h5);
        chk("pass_data", cp0_wdata, 32'h0000_abcd);
        cpu_mtc0 = 1'b0;

        // enabled syscall, with an MTC0 in the accepting cycle
        cp0_status = 32'h0000_000f; cp0_cause = 32'h0; ex_pc = 32'h0000_0100;
        req_syscall = 1'b1; cpu_mtc0 = 1'b1; cpu_addr = 5'd9; cpu_wdata = 32'h1234;
        #1;
        chk("sys_acc_stall", 32'(stall), 32'h0);
        chk("sys_acc_mtc0", cp0_wdata, 32'h1234);
        step(); req_syscall = 1'b0; cpu_mtc0 = 1'b0; #1;
        chk_write("sys_epc", 5'd14, 32'h0000_0100);
        step(); chk_write("sys_cause", 5'd13, 32'h0000_0020);
        step(); chk_write("sys_status", 5'd12, 32'h0000_01e0);
        step(); chk_redir("sys_redir", 32'h0000_0004);
        step(); chk_idle("sys_done");

        // masked break
        cp0_status = 32'h0000_000b; ex_pc = 32'h0000_0200; req_break = 1'b1;
        step(); req_break = 1'b0; #1;
        chk_redir("brk_skip", 32'h0000_0204);
        step(); chk_idle("brk_done");

        // eret
        cp0_status = 32'h0000_01e0; cp0_epc = 32'h0000_0100; req_eret = 1'b1;
        step(); req_eret = 1'b0; #1;
        chk_write("eret_st", 5'd12, 32'h0000_000f);
        step(); chk_redir("eret_red", 32'h0000_0100);
        step(); chk_idle("eret_done");

        // interrupt on line 2, one-cycle pulse
        cp0_status = 32'h0000_1001; ex_pc = 32'h0000_0300; irq = 6'b000100;
        step(); irq = '0; #1;
        chk_idle("int_latch");
        step(); chk_write("int_epc", 5'd14, 32'h0000_0300);
        step(); chk_write("int_cause", 5'd13, 32'h0000_1000);
        step(); chk_write("int_status", 5'd12, 32'h0002_0020);
        step(); chk_redir("int_redir", 32'h0000_0004);
        step(); chk_idle("int_done");
        step(); chk_idle("int_cleared");

        // teq wins over a pending irq[0]; core MTC0 ignored in W_CAUSE
        cp0_status = 32'h0000_0408; irq = 6'b000001;
        step(); irq = '0; #1;
        chk_idle("teq_pend");
        ex_pc = 32'h0000_0400; req_teq = 1'b1;
        step(); req_teq = 1'b0; #1;
        chk_write("teq_epc", 5'd14, 32'h0000_0400);
        step(); cpu_mtc0 = 1'b1; cpu_addr = 5'd12; cpu_wdata = 32'h0000_dead; #1;
        chk_write("teq_cause", 5'd13, 32'h0000_0034);
        step(); cpu_mtc0 = 1'b0; #1;
        chk_write("teq_status", 5'd12, 32'h0000_8100);
        step(); chk_redir("teq_redir", 32'h0000_0004);
        step(); chk_idle("teq_done");
        cp0_status = 32'h0000_0409; ex_pc = 32'h0000_0404;
        step(); chk_write("irq0_epc", 5'd14, 32'h0000_0404);
        step(); chk_write("irq0_cause", 5'd13, 32'h0000_0400);
        step(); step(); step();
        chk_idle("irq0_done");

        // reset during W_CAUSE aborts the sequence
        cp0_status = 32'h0000_000f; ex_pc = 32'h0000_0500; req_syscall = 1'b1;
        step(); req_syscall = 1'b0;
        step(); chk("abort_pre_addr", 32'(cp0_waddr), 32'd13);
        rst = 1'b0; #1;
        chk("abort_we", 32'(cp0_we), 32'h0);
        chk("abort_waddr", 32'(cp0_waddr), 32'h0);
        chk("abort_wdata", cp0_wdata, 32'h0);
        chk("abort_rpc", redirect_pc, 32'h0);
        chk_idle("abort");
        step(); rst = 1'b1; #1;
        chk_idle("abort_rel");
        step(); chk_idle("abort_rel2");
        chk("abort_rel_we", 32'(cp0_we), 32'h0);

        // wrap of ex_pc+4 on a masked syscall
        cp0_status = 32'h0; ex_pc = 32'hffff_fffc; req_syscall = 1'b1;
        step(); req_syscall = 1'b0; #1;
        chk_redir("wrap", 32'h0000_0000);
        step(); chk_idle("wrap_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
